// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single DATA_MEM port between the CPU MEM stage and a debug/loader master.
// The CPU has priority, and a starvation counter forces debug through. Define DMEM_ARB_PERF_EN to enable the perf counters.
module dmem_port_arbiter #(
   parameter int unsigned ADDR_W       = 64,
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_mem_read,
   input  logic              cpu_mem_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       perf_cpu_stalls,
   output logic [31:0]       perf_dbg_grants
);

   localparam int unsigned      CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIM   = CNT_W'(STARVE_LIMIT);

   typedef enum logic {ST_IDLE, ST_DBG_ACK} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic              dbg_ack_q, dbg_ack_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              cpu_act;
   logic              dbg_grant;
   logic              cpu_grant;

   // Debug only wins from ST_IDLE: when the CPU is quiet, or once the CPU has used up its contended budget.
   always_comb begin
      cpu_act   = cpu_mem_read | cpu_mem_write;
      dbg_grant = 1'b0;
      cpu_grant = 1'b0;
      if (state_q == ST_IDLE && dbg_req && (!cpu_act || starve_cnt_q == LIM)) begin
         dbg_grant = 1'b1;
      end else if (cpu_act) begin
         cpu_grant = 1'b1;
      end
   end

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (dbg_grant) begin
         mem_read  = ~dbg_we;
         mem_write = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end else if (cpu_grant) begin
         mem_read  = cpu_mem_read & ~cpu_mem_write;
         mem_write = cpu_mem_write;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end
      if (reset) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end
   end

   assign cpu_stall = cpu_act & dbg_grant & ~reset;
   assign cpu_rdata = mem_rdata;
   assign dbg_ack   = dbg_ack_q;
   assign dbg_rdata = dbg_rdata_q;

   always_comb begin
      state_d      = ST_IDLE;
      starve_cnt_d = starve_cnt_q;
      dbg_ack_d    = dbg_grant;
      dbg_rdata_d  = dbg_rdata_q;
      if (dbg_grant) begin
         state_d      = ST_DBG_ACK;
         starve_cnt_d = '0;
         if (!dbg_we) begin
            dbg_rdata_d = mem_rdata;
         end
      end else if (state_q == ST_IDLE && dbg_req && cpu_grant && starve_cnt_q != LIM) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         starve_cnt_q <= '0;
         dbg_ack_q    <= 1'b0;
         dbg_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         dbg_ack_q    <= dbg_ack_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_grant_q, perf_grant_d;

   always_comb begin
      perf_stall_d = perf_stall_q + {31'b0, cpu_stall};
      perf_grant_d = perf_grant_q + {31'b0, dbg_grant};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_stall_q <= '0;
         perf_grant_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_grant_q <= perf_grant_d;
      end
   end

   assign perf_cpu_stalls = perf_stall_q;
   assign perf_dbg_grants = perf_grant_q;
`else
   assign perf_cpu_stalls = '0;
   assign perf_dbg_grants = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: directed scenarios followed by randomized traffic.
// Every cycle is checked against a cycle-level behavioural model of the arbitration rules.
module tb_dmem_port_arbiter;

   localparam int unsigned AW  = 64;
   localparam int unsigned DW  = 64;
   localparam int unsigned LIM = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          cpu_mem_read, cpu_mem_write;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          cpu_stall;
   logic          dbg_req, dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata, dbg_rdata;
   logic          dbg_ack;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [31:0]   perf_cpu_stalls, perf_dbg_grants;

   dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
      .clock(clock), .reset(reset),
      .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .perf_cpu_stalls(perf_cpu_stalls), .perf_dbg_grants(perf_dbg_grants)
   );

   always #5 clock = ~clock;

   // Data memory stand-in, driven by the DUT port; combinational read.
   logic [DW-1:0] env_mem [16] = '{default: '0};
   assign mem_rdata = env_mem[mem_addr[3:0]];
   always @(posedge clock) if (mem_write) env_mem[mem_addr[3:0]] <= mem_wdata;

   // Reference model state.
   logic [DW-1:0] ref_mem [16];
   int unsigned   m_starve;
   bit            m_in_ack;
   logic [DW-1:0] m_rdata;
   int unsigned   m_stalls, m_grants;
   int unsigned   n_checks, n_errors;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle with the current inputs: combinational checks before the edge, state checks after.
   task automatic step();
      bit            act, win, e_rd, e_wr, e_stall;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      #2;
      act     = cpu_mem_read | cpu_mem_write;
      win     = !m_in_ack && dbg_req && (!act || m_starve >= LIM);
      e_rd    = 1'b0;
      e_wr    = 1'b0;
      e_addr  = '0;
      e_wdata = '0;
      e_stall = act && win;
      if (win) begin
         e_rd = !dbg_we; e_wr = dbg_we; e_addr = dbg_addr; e_wdata = dbg_wdata;
      end else if (act) begin
         e_rd = cpu_mem_read && !cpu_mem_write; e_wr = cpu_mem_write;
         e_addr = cpu_addr; e_wdata = cpu_wdata;
      end
      if (reset) begin
         check("rst_mem_read", mem_read, 0);
         check("rst_mem_write", mem_write, 0);
         check("rst_cpu_stall", cpu_stall, 0);
         check("rst_dbg_ack", dbg_ack, 0);
         check("rst_dbg_rdata", dbg_rdata, 0);
      end else begin
         check("mem_read", mem_read, e_rd);
         check("mem_write", mem_write, e_wr);
         check("mem_addr", mem_addr, e_addr);
         check("cpu_stall", cpu_stall, e_stall);
         check("cpu_rdata", cpu_rdata, ref_mem[e_addr[3:0]]);
         if (e_wr || (!win && !act)) check("mem_wdata", mem_wdata, e_wdata);
      end
      @(posedge clock);
      #1;
      if (reset) begin
         m_starve = 0; m_in_ack = 1'b0; m_rdata = '0; m_stalls = 0; m_grants = 0;
      end else begin
         if (win && !dbg_we) m_rdata = ref_mem[e_addr[3:0]];
         if (e_wr) ref_mem[e_addr[3:0]] = e_wdata;
         if (win) m_starve = 0;
         else if (!m_in_ack && dbg_req && act && m_starve < LIM) m_starve++;
         m_stalls += int'(e_stall);
         m_grants += int'(win);
         m_in_ack = win;
      end
      check("dbg_ack", dbg_ack, m_in_ack);
      check("dbg_rdata", dbg_rdata, m_rdata);
`ifdef DMEM_ARB_PERF_EN
      check("perf_cpu_stalls", perf_cpu_stalls, m_stalls);
      check("perf_dbg_grants", perf_dbg_grants, m_grants);
`else
      check("perf_cpu_stalls", perf_cpu_stalls, 0);
      check("perf_dbg_grants", perf_dbg_grants, 0);
`endif
   endtask

   task automatic idle_inputs();
      cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      m_starve = 0; m_in_ack = 1'b0; m_rdata = '0; m_stalls = 0; m_grants = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      idle_inputs();
      cpu_mem_write = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 64'd5; dbg_wdata = 64'h55;
      #1 reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      idle_inputs();
      step();

      // Debug write then read-back with no CPU traffic.
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 64'd8; dbg_wdata = 64'hDEAD;
      step();
      check("t2_wr_ack", dbg_ack, 1);
      step();
      dbg_we = 1'b0;
      step();
      check("t2_rd_data", dbg_rdata, 64'hDEAD);
      step();
      idle_inputs();
      step();

      // Starvation: CPU reads every cycle while debug waits.
      cpu_mem_read = 1'b1; cpu_addr = 64'd2;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 64'd8;
      for (int c = 0; c < 4; c++) begin
         step();
         check("t3_no_ack", dbg_ack, 0);
      end
      step();
      check("t3_ack", dbg_ack, 1);
      step();
      dbg_req = 1'b0;
      step();
      dbg_req = 1'b1; dbg_addr = 64'd3;
      repeat (7) step();
      idle_inputs();
      step();

      // Back-to-back debug reads with the CPU idle.
      dbg_req = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         dbg_addr = AW'(k);
         step();
         check("t4_ack_hi", dbg_ack, 1);
         step();
         check("t4_ack_lo", dbg_ack, 0);
      end
      idle_inputs();

      // CPU read and write together: write wins.
      cpu_mem_read = 1'b1; cpu_mem_write = 1'b1; cpu_addr = 64'd6; cpu_wdata = 64'hBEEF;
      step();
      idle_inputs();
      step();

      // Reset in the grant cycle of a debug read.
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 64'd8;
      #1 reset = 1'b1;
      #1 check("t6_rdata_async", dbg_rdata, 0);
      step();
      reset = 1'b0;
      dbg_req = 1'b0;
      step();
      check("t6_no_ack", dbg_ack, 0);

      // Randomized traffic; the debug master holds each request until its ack.
      repeat (3000) begin
         cpu_mem_read  = ($urandom_range(0, 3) != 0);
         cpu_mem_write = ($urandom_range(0, 4) == 0);
         cpu_addr      = AW'($urandom_range(0, 15));
         cpu_wdata     = {$urandom, $urandom};
         reset         = ($urandom_range(0, 199) == 0);
         step();
         if (reset || m_in_ack || !dbg_req) begin
            if (!reset && $urandom_range(0, 1) == 1) begin
               dbg_req   = 1'b1;
               dbg_we    = 1'($urandom_range(0, 1));
               dbg_addr  = AW'($urandom_range(0, 15));
               dbg_wdata = {$urandom, $urandom};
            end else begin
               dbg_req = 1'b0;
            end
         end
      end
      reset = 1'b0;
      idle_inputs();
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
